// File: rtl/wb_regfile_if.sv
// Writeback-stage bus for wb_regfile: the MEM/WB inputs, the ID read ports and the
// forwarding and count outputs.
interface wb_regfile_if;
  logic [31:0] addr_in;
  logic [31:0] data_in;
  logic [31:0] pc_4_in;
  logic [4:0]  rd_in;
  logic [2:0]  WB_ctrl_in;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] wb_data_out;
  logic        wb_en_out;
  logic [31:0] wb_count;

  modport master (
    output addr_in, data_in, pc_4_in, rd_in, WB_ctrl_in, rs1_addr, rs2_addr,
    input  rs1_data, rs2_data, wb_data_out, wb_en_out, wb_count
  );

  modport slave (
    input  addr_in, data_in, pc_4_in, rd_in, WB_ctrl_in, rs1_addr, rs2_addr,
    output rs1_data, rs2_data, wb_data_out, wb_en_out, wb_count
  );
endinterface

// File: rtl/wb_regfile.sv
// Writeback stage and 32x32 register file: selects the writeback value, writes it
// with one edge of latency, and serves two combinational read ports with bypass.
module wb_regfile (
  input logic         clk,
  input logic         rst,
  wb_regfile_if.slave bus
);
  logic [31:0] regs [32];
  logic [31:0] cnt_q;
  logic [31:0] wb_data;
  logic        wb_en;
  logic        reg_write;
  logic [1:0]  wb_sel;

  assign reg_write = bus.WB_ctrl_in[2];
  assign wb_sel    = bus.WB_ctrl_in[1:0];

  always_comb begin
    wb_data = 32'h0;
    case (wb_sel)
      2'b00:   wb_data = bus.addr_in;
      2'b01:   wb_data = bus.data_in;
      2'b10:   wb_data = bus.pc_4_in;
      default: wb_data = 32'h0;
    endcase
  end

  // Reserved select and x0 targets are dropped here so they never reach the array or count.
  assign wb_en = reg_write && (bus.rd_in != 5'd0) && (wb_sel != 2'b11);

  always_comb begin
    bus.rs1_data = 32'h0;
    if (bus.rs1_addr == 5'd0)
      bus.rs1_data = 32'h0;
    else if (wb_en && (bus.rs1_addr == bus.rd_in))
      bus.rs1_data = wb_data;
    else
      bus.rs1_data = regs[bus.rs1_addr];
  end

  always_comb begin
    bus.rs2_data = 32'h0;
    if (bus.rs2_addr == 5'd0)
      bus.rs2_data = 32'h0;
    else if (wb_en && (bus.rs2_addr == bus.rd_in))
      bus.rs2_data = wb_data;
    else
      bus.rs2_data = regs[bus.rs2_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
      cnt_q <= 32'h0;
    end else if (wb_en) begin
      regs[bus.rd_in] <= wb_data;
      cnt_q           <= cnt_q + 32'd1;
    end
  end

  assign bus.wb_data_out = wb_data;
  assign bus.wb_en_out   = wb_en;
  assign bus.wb_count    = cnt_q;
endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: directed scenarios plus random traffic checked
// against an array-based register model.
module tb_wb_regfile;
  logic clk = 1'b0;
  logic rst = 1'b1;

  wb_regfile_if bus ();

  wb_regfile dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] wbd;
    logic        wbe;
    logic [31:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_regs [32];
  logic [31:0] model_cnt;
  int          n_checks = 0;
  int          n_errors = 0;
  bit          stim_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic exp_t predict(input string tag);
    exp_t        e;
    logic [1:0]  sel;
    sel   = bus.WB_ctrl_in[1:0];
    e.tag = tag;
    case (sel)
      2'd0:    e.wbd = bus.addr_in;
      2'd1:    e.wbd = bus.data_in;
      2'd2:    e.wbd = bus.pc_4_in;
      default: e.wbd = 32'h0;
    endcase
    e.wbe = bus.WB_ctrl_in[2] && (bus.rd_in != 0) && (sel != 2'd3);
    if (bus.rs1_addr == 0)                          e.rs1 = 32'h0;
    else if (e.wbe && bus.rs1_addr == bus.rd_in)    e.rs1 = e.wbd;
    else                                            e.rs1 = model_regs[bus.rs1_addr];
    if (bus.rs2_addr == 0)                          e.rs2 = 32'h0;
    else if (e.wbe && bus.rs2_addr == bus.rd_in)    e.rs2 = e.wbd;
    else                                            e.rs2 = model_regs[bus.rs2_addr];
    e.cnt = model_cnt;
    return e;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
    model_cnt = 32'h0;
  endtask

  // One bus cycle: drive at the falling edge, queue the expectation, then commit
  // what the coming rising edge should do to the model.
  task automatic step(input string tag, input logic r, input logic [2:0] ctrl,
                      input logic [4:0] rd, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] pc, input logic [4:0] ra1, input logic [4:0] ra2,
                      input bit backdoor_full);
    exp_t e;
    @(negedge clk);
    if (backdoor_full) begin
      dut.cnt_q = 32'hFFFF_FFFF;
      model_cnt = 32'hFFFF_FFFF;
    end
    rst            = r;
    bus.WB_ctrl_in = ctrl;
    bus.rd_in      = rd;
    bus.addr_in    = a;
    bus.data_in    = d;
    bus.pc_4_in    = pc;
    bus.rs1_addr   = ra1;
    bus.rs2_addr   = ra2;
    if (r) clear_model();
    e = predict(tag);
    exp_q.push_back(e);
    if (!r && e.wbe) begin
      model_regs[rd] = e.wbd;
      model_cnt      = model_cnt + 1;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      wait (exp_q.size() != 0);
      #1;
      e = exp_q.pop_front();
      chk({e.tag, ".rs1_data"},    bus.rs1_data,           e.rs1);
      chk({e.tag, ".rs2_data"},    bus.rs2_data,           e.rs2);
      chk({e.tag, ".wb_data_out"}, bus.wb_data_out,        e.wbd);
      chk({e.tag, ".wb_en_out"},   {31'h0, bus.wb_en_out}, {31'h0, e.wbe});
      chk({e.tag, ".wb_count"},    bus.wb_count,           e.cnt);
    end
  end

  initial begin : stimulus
    exp_t e;
    clear_model();
    bus.WB_ctrl_in = 3'b000;
    bus.rd_in      = '0;
    bus.addr_in    = '0;
    bus.data_in    = '0;
    bus.pc_4_in    = '0;
    bus.rs1_addr   = 5'd5;
    bus.rs2_addr   = 5'd9;

    step("reset",    1'b1, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd9, 1'b0);
    step("rst_wr",   1'b1, 3'b100, 5'd5, 32'h5555_0000, 32'h0, 32'h0, 5'd5, 5'd6, 1'b0);
    step("write_alu", 1'b0, 3'b100, 5'd5, 32'h1234_5678, 32'h0, 32'h0, 5'd1, 5'd2, 1'b0);
    step("read_alu", 1'b0, 3'b000, 5'd5, 32'h0, 32'h0, 32'h0, 5'd5, 5'd5, 1'b0);
    step("x0_write", 1'b0, 3'b101, 5'd0, 32'h0, 32'hDEAD_BEEF, 32'h0, 5'd0, 5'd5, 1'b0);
    step("x0_read",  1'b0, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0);
    step("set_r7",   1'b0, 3'b100, 5'd7, 32'h1, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0);
    step("bypass",   1'b0, 3'b110, 5'd7, 32'h0, 32'h0, 32'h40, 5'd7, 5'd7, 1'b0);
    step("after_byp", 1'b0, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 5'd7, 5'd7, 1'b0);
    step("set_r3",   1'b0, 3'b101, 5'd3, 32'h0, 32'h3333_3333, 32'h0, 5'd3, 5'd0, 1'b0);
    step("reserved", 1'b0, 3'b111, 5'd3, 32'hAAAA, 32'hBBBB, 32'hCCCC, 5'd3, 5'd3, 1'b0);
    step("bubble",   1'b0, 3'b000, 5'd3, 32'hAAAA, 32'hBBBB, 32'hCCCC, 5'd3, 5'd3, 1'b0);
    step("post_bub", 1'b0, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 5'd3, 5'd7, 1'b0);

    step("write_r9", 1'b0, 3'b100, 5'd9, 32'hAA, 32'h0, 32'h0, 5'd9, 5'd1, 1'b0);
    step("read_r9",  1'b0, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 5'd9, 5'd9, 1'b0);
    // Assert reset between edges: state must clear with no clock.
    #2;
    rst = 1'b1;
    clear_model();
    e = predict("async_rst");
    exp_q.push_back(e);
    #2;
    step("rst_hold", 1'b1, 3'b100, 5'd9, 32'hBB, 32'h0, 32'h0, 5'd9, 5'd2, 1'b0);
    step("first_wr", 1'b0, 3'b101, 5'd2, 32'h0, 32'hCAFE_F00D, 32'h0, 5'd9, 5'd2, 1'b0);
    step("read_r2",  1'b0, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 5'd2, 5'd9, 1'b0);

    step("wrap_wr",  1'b0, 3'b100, 5'd11, 32'h0B0B, 32'h0, 32'h0, 5'd11, 5'd0, 1'b1);
    step("wrap_rd",  1'b0, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 5'd11, 5'd0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      step("random", ($urandom_range(0, 49) == 0), 3'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'b0);
    end

    step("drain",    1'b0, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 5'd1, 5'd4, 1'b0);
    stim_done = 1'b1;
  end

  initial begin : finisher
    int budget;
    budget = 0;
    wait (stim_done);
    while (exp_q.size() != 0 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    #3;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain_timeout: pending %0d expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 The block SHALL have a single clock `clk`, on which all state updates on the rising edge.
REQ-002 The block SHALL have reset `rst`, asynchronous and active-high.
REQ-003 `addr_in` SHALL be an input, 32 bits, carrying the ALU result / address from the MEM/WB stage.
REQ-004 `data_in` SHALL be an input, 32 bits, carrying the memory load data from the MEM/WB stage.
REQ-005 `pc_4_in` SHALL be an input, 32 bits, carrying the link value (PC+4) from the MEM/WB stage.
REQ-006 `rd_in` SHALL be an input, 5 bits, giving the destination register index.
REQ-007 `WB_ctrl_in` SHALL be an input, 3 bits: bit2 is reg_write; bits[1:0] are wb_sel (00 addr, 01 data, 10 pc_4, 11 reserved).
REQ-008 `rs1_addr` and `rs2_addr` SHALL be inputs, 5 bits each, giving the ID-stage read indices.
REQ-009 `rs1_data` and `rs2_data` SHALL be outputs, 32 bits each, giving the read operands.
REQ-010 `wb_data_out` SHALL be an output, 32 bits, giving the selected writeback value for EX forwarding.
REQ-011 `wb_en_out` SHALL be an output, 1 bit, indicating an effective write in the current cycle.
REQ-012 `wb_count` SHALL be an output, 32 bits, giving the number of retired register writes.

Function
REQ-013 wb_data_out SHALL be combinational: wb_sel 00 gives addr_in, 01 gives data_in, 10 gives pc_4_in, and 11 gives 0.
REQ-014 wb_en_out SHALL equal reg_write AND (rd_in != 0) AND (wb_sel != 11).
REQ-015 The register file SHALL be 32 entries of 32 bits.
REQ-016 When wb_en_out is 1 at a rising clk edge, regs[rd_in] SHALL be written with wb_data_out; latency is 1 edge.
REQ-017 Entry x0 SHALL never be written and SHALL always read 0.
REQ-018 Reads SHALL be combinational: rsN_data = 0 if rsN_addr == 0; else wb_data_out if wb_en_out and rsN_addr == rd_in (write-through bypass); else regs[rsN_addr].
REQ-019 Both read ports SHALL be independent; identical addresses on both ports SHALL return identical data.
REQ-020 wb_count SHALL increment by 1 on each edge where wb_en_out is 1 and SHALL wrap from 0xFFFFFFFF to 0.
REQ-021 A write with reserved wb_sel 11 SHALL be dropped silently: no register update and no count increment.
REQ-022 A bubble (WB_ctrl_in = 0, as produced by a flushed MEM/WB register) SHALL cause no state change.

Reset
REQ-023 While rst is high, all 32 entries and wb_count SHALL be held at 0, independent of clk.
REQ-024 rst SHALL override any write in progress; a write at the same edge as rst assertion SHALL be lost.
REQ-025 Because the outputs are combinational, during reset rsN_data SHALL be 0 unless bypassed.
REQ-026 wb_data_out and wb_en_out SHALL follow the inputs during reset, but no write SHALL take effect.
REQ-027 After rst deasserts, the first qualifying edge SHALL write normally.

Verification
REQ-028 Scenario write-ALU: rst, then WB_ctrl=100, rd=5, addr_in=0x12345678, one edge, then rs1_addr=5 -> rs1_data=0x12345678 and wb_count=1.
REQ-029 Scenario x0: WB_ctrl=101, rd=0, data_in=0xDEADBEEF -> wb_en_out=0; rs1_addr=0 reads 0; wb_count unchanged.
REQ-030 Scenario bypass: regs[7]=0x1; WB_ctrl=110, rd=7, pc_4_in=0x40 before the edge -> rs1_data=rs2_data=0x40 combinationally; after the edge regs[7]=0x40.
REQ-031 Scenario reserved/bubble: WB_ctrl=111 or 000 with rd=3 -> regs[3] and wb_count unchanged.
REQ-032 Scenario async reset: write regs[9]=0xAA, then assert rst mid-cycle with no clk edge -> rs1_addr=9 reads 0 immediately and wb_count=0.
REQ-033 Scenario wrap: force wb_count to 0xFFFFFFFF via 2^32-1 writes (or a bench backdoor), then one write -> wb_count=0.
